// File: rtl/multiplier_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the default operand width.
package multiplier_seq_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/Adder1Bit.sv
// Single-bit full adder cell used as the building block of the ripple adder.
module Adder1Bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_nbit.sv
// WIDTH-bit ripple-carry adder built from chained Adder1Bit cells; carry-in
// is tied to 0 and the final carry is exported.
module adder_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    Adder1Bit u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/multiplier_seq.sv
// Sequential radix-2 shift-add multiplier with valid/ready handshakes.
// Signed operands are multiplied as magnitudes and the sign is applied in FIX.
module multiplier_seq
  import multiplier_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
  input  logic               signed_mode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic [PW-1:0]    p_q, p_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [PW:0]      acc_step;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sm);
    return (sm && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  adder_nbit #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_q[PW-1:WIDTH]),
    .b    (mcand_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Carry lands in bit 2*WIDTH before the right shift drops bit 0.
  assign acc_step = acc_q[0] ? {add_cout, add_sum, acc_q[WIDTH-1:0]}
                             : {1'b0, acc_q};

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = magnitude(m, signed_mode);
          acc_d   = {{WIDTH{1'b0}}, magnitude(q, signed_mode)};
          sign_d  = signed_mode & (m[WIDTH-1] ^ q[WIDTH-1]);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_step[PW:1];
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIX: begin
        p_d         = sign_q ? (~acc_q + PW'(1)) : acc_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign p         = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_seq.sv
// Self-checking bench for multiplier_seq at WIDTH=4: directed vector table,
// backpressure, mid-operation reset, input scrambling and random operands.
module tb_multiplier_seq;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   m, q;
  logic           signed_mode;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] p;
  logic           out_valid;
  logic           out_ready;

  int tests = 0;
  int fails = 0;

  multiplier_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m           (m),
    .q           (q),
    .signed_mode (signed_mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .p           (p),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sm;
    logic [2*W-1:0] exp_p;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer product of the operands as interpreted by the mode.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sm);
    int x, y;
    if (sm) begin
      x = $signed(a);
      y = $signed(b);
    end else begin
      x = a;
      y = b;
    end
    return (2*W)'(x * y);
  endfunction

  // One full transaction; scramble perturbs inputs while busy, hold adds
  // backpressure cycles after out_valid rises.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        input logic [2*W-1:0] exp_p, input string name,
                        input bit scramble, input int hold);
    int lat;
    logic [2*W-1:0] p_seen;
    @(negedge clk);
    m = a; q = b; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b0;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (scramble) begin
        m = W'($urandom); q = W'($urandom); signed_mode = 1'($urandom);
        in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({name, "_latency"}, 32'(lat), 32'd5);
    check({name, "_p"}, 32'(p), 32'(exp_p));
    p_seen = p;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      m = W'($urandom); q = W'($urandom);
      @(posedge clk); #1;
      check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({name, "_hold_p"}, 32'(p), 32'(p_seen));
      check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_release_valid"}, 32'(out_valid), 32'd0);
    check({name, "_release_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{a: 4'd3,  b: 4'd5,  sm: 1'b0, exp_p: 8'h0F};
    vecs[1] = '{a: 4'd15, b: 4'd15, sm: 1'b0, exp_p: 8'hE1};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  sm: 1'b0, exp_p: 8'h00};
    vecs[3] = '{a: 4'hD,  b: 4'd5,  sm: 1'b1, exp_p: 8'hF1};
    vecs[4] = '{a: 4'h8,  b: 4'h8,  sm: 1'b1, exp_p: 8'h40};
    vecs[5] = '{a: 4'h8,  b: 4'h1,  sm: 1'b1, exp_p: 8'hF8};
    vecs[6] = '{a: 4'hF,  b: 4'h7,  sm: 1'b1, exp_p: 8'hF9};

    rst_n = 1'b0; m = '0; q = '0; signed_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_p", 32'(p), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp_p, $sformatf("vec%0d", i), 1'b0, 0);

    run_op(4'd7, 4'd3, 1'b0, 8'h15, "backpressure", 1'b0, 3);

    // Abort during the second CALC iteration; p currently holds 0x15.
    @(negedge clk);
    m = 4'd5; q = 4'd5; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_p", 32'(p), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd2, 4'd7, 1'b0, 8'h0E, "after_reset", 1'b0, 0);

    run_op(4'd6, 4'd6, 1'b0, 8'h24, "input_change", 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      logic sm;
      a = W'($urandom); b = W'($urandom); sm = 1'($urandom);
      run_op(a, b, sm, ref_mul(a, b, sm), $sformatf("rand%0d", i),
             1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
